// File: rtl/ov_sccb_resp.sv
// SCCB register-access responder: 3-phase write, 2-phase write + 2-phase read.
// Define OV_SCCB_RESP_ACK_EN to drive an I2C-style ACK in the 9th-bit phases.
module ov_sccb_resp #(
  parameter logic [7:0] CHIP_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sio_c,
  input  logic       sio_d_i,
  output logic       sio_d_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X,
    S_WDAT, S_WDAT_X, S_RDAT, S_RDAT_X, S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic        scl_s1_q, scl_s2_q, scl_p_q;
  logic        sda_s1_q, sda_s2_q, sda_p_q;
  logic [1:0]  arm_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;

  logic        armed, scl_rise, scl_fall, start_det, stop_det, in_byte;
  logic [7:0]  byte_in;

  // Synchronizers; edge detection stays off until the pipeline has flushed
  // after reset, so a line already low at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_p_q  <= 1'b1;
      arm_q    <= 2'd0;
    end else begin
      scl_s1_q <= sio_c;
      scl_s2_q <= scl_s1_q;
      scl_p_q  <= scl_s2_q;
      sda_s1_q <= sio_d_i;
      sda_s2_q <= sda_s1_q;
      sda_p_q  <= sda_s2_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  assign armed     = (arm_q == 2'd3);
  assign scl_rise  = armed & scl_s2_q & ~scl_p_q;
  assign scl_fall  = armed & ~scl_s2_q & scl_p_q;
  assign start_det = armed & scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_det  = armed & scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  assign in_byte   = (state_q == S_ID) || (state_q == S_SUB) ||
                     (state_q == S_WDAT) || (state_q == S_RDAT);
  assign byte_in   = {sh_q[6:0], sda_s2_q};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Byte states hand over to their 9th-bit state on the SCL fall after bit 8;
  // each *_X state ends on the following SCL fall.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ID;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else if (scl_fall) begin
      case (state_q)
        S_ID:     if (cnt_q == 4'd8)
                    state_d = (sh_q[7:1] == CHIP_ADDR[7:1]) ? S_ID_X : S_IGNORE;
        S_ID_X:   state_d = rw_q ? S_RDAT : S_SUB;
        S_SUB:    if (cnt_q == 4'd8) state_d = S_SUB_X;
        S_SUB_X:  state_d = S_WDAT;
        S_WDAT:   if (cnt_q == 4'd8) state_d = S_WDAT_X;
        S_WDAT_X: state_d = S_IGNORE;
        S_RDAT:   if (cnt_q == 4'd8) state_d = S_RDAT_X;
        S_RDAT_X: state_d = S_IGNORE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    if (start_det || stop_det) begin
      cnt_d = 4'd0;
    end else begin
      if (scl_rise && in_byte && (cnt_q != 4'd8)) begin
        sh_d  = byte_in;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          if (state_q == S_SUB) rd_addr_d = byte_in;
          if (state_q == S_WDAT) begin
            wr_addr_d = rd_addr_q;
            wr_data_d = byte_in;
            wr_en_d   = 1'b1;
          end
        end
      end
      if (scl_fall) begin
        if (in_byte && (cnt_q == 4'd8)) cnt_d = 4'd0;
        if ((state_q == S_ID) && (cnt_q == 4'd8)) rw_d = sh_q[0];
        if ((state_q == S_RDAT) && (cnt_q != 4'd8)) tx_d = {tx_q[6:0], 1'b0};
        if ((state_q == S_ID_X) && rw_q) tx_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      rd_addr_q <= 8'd0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      wr_en_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    tx_q <= tx_d;
    rw_q <= rw_d;
  end

  // All inputs here change only on SCL falls (or START/STOP/reset).
  always_comb begin
    sio_d_oe = 1'b0;
    case (state_q)
      S_RDAT:   sio_d_oe = ~tx_q[7];
`ifdef OV_SCCB_RESP_ACK_EN
      S_ID_X:   sio_d_oe = ~rw_q;
      S_SUB_X:  sio_d_oe = 1'b1;
      S_WDAT_X: sio_d_oe = 1'b1;
`endif
      default:  sio_d_oe = 1'b0;
    endcase
    busy = (state_q != S_IDLE);
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ov_sccb_resp.sv
// Bench for ov_sccb_resp: SCCB master model, transaction-level reference
// model and randomized transfers; honours OV_SCCB_RESP_ACK_EN.
`timescale 1ns/1ps
module tb_ov_sccb_resp;

  localparam logic [7:0] CHIP = 8'h42;
`ifdef OV_SCCB_RESP_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sio_c = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sio_d_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];

  assign sda_line = sda_m & ~sio_d_oe;
  assign rd_data  = mem[rd_addr];

  always #10 clk = ~clk;

  ov_sccb_resp #(.CHIP_ADDR(CHIP)) dut (
    .clk(clk), .reset(reset), .sio_c(sio_c), .sio_d_i(sda_line),
    .sio_d_oe(sio_d_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int wr_cnt = 0, wide_cnt = 0, oe_rises = 0;
  logic wr_en_prev = 1'b0, oe_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_en) wr_cnt++;
    if (wr_en && wr_en_prev) wide_cnt++;
    if (sio_d_oe && !oe_prev) oe_rises++;
    wr_en_prev = wr_en;
    oe_prev    = sio_d_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: register-visible effect of each completed transfer.
  int         exp_wr = 0;
  logic [7:0] exp_wa = 8'h00, exp_wd = 8'h00, exp_rd = 8'h00;
  int unsigned q_ns = 2500;

  task automatic m_start();
    sda_m = 1'b1; #(q_ns);
    sio_c = 1'b1; #(q_ns);
    sda_m = 1'b0; #(q_ns);
    sio_c = 1'b0; #(q_ns);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; #(q_ns);
    sio_c = 1'b1; #(q_ns);
    sda_m = 1'b1; #(q_ns);
  endtask

  task automatic m_bit(input logic b, output logic seen);
    sda_m = b;    #(q_ns);
    sio_c = 1'b1; #(q_ns);
    seen  = sda_line; #(q_ns);
    sio_c = 1'b0; #(q_ns);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_rbyte(output logic [7:0] d, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #(q_ns);
      sio_c = 1'b1; #(q_ns);
      d[i]  = sda_line; #(q_ns);
      sio_c = 1'b0; #(q_ns);
    end
    sda_m = 1'b1; #(q_ns);
    sio_c = 1'b1; #(q_ns);
    oe9   = sio_d_oe; #(q_ns);
    sio_c = 1'b0; #(q_ns);
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_wa));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(exp_wd));
    chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(exp_rd));
    chk({tag, ".wr_width"}, 32'(wide_cnt), 32'd0);
  endtask

  // nb = number of bytes after the ID (1 = 2-phase, 2 = 3-phase write).
  task automatic txn_write(input string tag, input logic [7:0] id, input int nb,
                           input logic [7:0] sub, input logic [7:0] dat, input bit stop);
    logic a;
    bit   match;
    match = (id[7:1] == CHIP[7:1]);
    m_start();
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    m_wbyte(id, a);
    chk({tag, ".ack_id"}, 32'(a), 32'(ACK_EN && match));
    if (nb >= 1) begin
      m_wbyte(sub, a);
      chk({tag, ".ack_sub"}, 32'(a), 32'(ACK_EN && match));
      if (match) exp_rd = sub;
    end
    if (nb >= 2) begin
      m_wbyte(dat, a);
      chk({tag, ".ack_dat"}, 32'(a), 32'(ACK_EN && match));
      if (match) begin
        exp_wr++;
        exp_wa = sub;
        exp_wd = dat;
      end
    end
    if (stop) begin
      m_stop();
      chk({tag, ".idle"}, 32'(busy), 32'd0);
      chk_regs(tag);
    end
  endtask

  task automatic txn_read(input string tag);
    logic       a, oe9;
    logic [7:0] v;
    m_start();
    m_wbyte(CHIP | 8'h01, a);
    chk({tag, ".ack_id"}, 32'(a), 32'd0);
    m_rbyte(v, oe9);
    chk({tag, ".rdata"}, 32'(v), 32'(mem[exp_rd]));
    chk({tag, ".oe_9th"}, 32'(oe9), 32'd0);
    m_stop();
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk_regs(tag);
  endtask

  initial begin
    logic       s;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h0A] = 8'h76;

    repeat (5) @(negedge clk);
    chk("rst.oe", 32'(sio_d_oe), 32'd0);
    chk("rst.wr_en", 32'(wr_en), 32'd0);
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.wr_data", 32'(wr_data), 32'd0);
    chk("rst.rd_addr", 32'(rd_addr), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 100 kHz SCL against 50 MHz clk
    q_ns = 2500;
    txn_write("w3_100k", 8'h42, 2, 8'h12, 8'h80, 1'b1);

    q_ns = 200;
    txn_write("w2", 8'h42, 1, 8'h0A, 8'h00, 1'b1);
    txn_read("rd76");

    oe_rises = 0;
    txn_write("badid", 8'h60, 2, 8'h11, 8'h00, 1'b0);
    chk("badid.busy_pre_stop", 32'(busy), 32'd1);
    m_stop();
    chk("badid.idle", 32'(busy), 32'd0);
    chk("badid.oe_rises", 32'(oe_rises), 32'd0);
    chk_regs("badid");

    txn_write("rs_a", 8'h42, 1, 8'h3A, 8'h00, 1'b0);
    txn_write("rs_b", 8'h42, 2, 8'h40, 8'hD0, 1'b1);

    // Reset pulse while SCL is high during data bit 3
    m_start();
    m_wbyte(8'h42, s);
    m_wbyte(8'h14, s);
    d = 8'h5C;
    for (int i = 7; i >= 4; i--) m_bit(d[i], s);
    sda_m = d[3]; #(q_ns);
    sio_c = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_rd = 8'h00; exp_wa = 8'h00; exp_wd = 8'h00;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.rd_addr", 32'(rd_addr), 32'd0);
    #(q_ns);
    sio_c = 1'b0; #(q_ns);
    for (int i = 2; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    chk("rstmid.busy_tail", 32'(busy), 32'd0);
    m_stop();
    chk_regs("rstmid");
    txn_write("after_rst", 8'h42, 2, 8'h14, 8'h18, 1'b1);

    oe_rises = 0;
    txn_write("ackcnt", 8'h42, 2, 8'h8C, 8'h00, 1'b1);
    chk("ackcnt.oe_rises", 32'(oe_rises), ACK_EN ? 32'd3 : 32'd0);

    for (int n = 0; n < 12; n++) begin
      int unsigned kind;
      logic [7:0]  id, sb, db;
      q_ns = 20 * $urandom_range(8, 10);
      kind = $urandom_range(0, 3);
      id   = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'hFE) : CHIP;
      sb   = 8'($urandom);
      db   = 8'($urandom);
      if (kind == 0) txn_read("rnd_rd");
      else txn_write("rnd_wr", id, (kind == 1) ? 1 : 2, sb, db, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
